// File: rtl/insn_fetch.sv
// insn_fetch: Wishbone instruction fetch master.
// Fetches one word per bus cycle and hands it to decode.
module insn_fetch #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 64,
  parameter logic [ADR_WIDTH-1:0] RESET_PC = '0,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  output logic [ADR_WIDTH-1:0] fetch_adr_o,
  input  logic [DAT_WIDTH-1:0] fetch_dat_i,
  output logic [DAT_WIDTH-1:0] fetch_dat_o,
  output logic                 fetch_we_o,
  output logic                 fetch_cyc_o,
  output logic                 fetch_stb_o,
  input  logic                 fetch_ack_i,
  input  logic                 fetch_err_i,
  output logic [DAT_WIDTH-1:0] insn_o,
  output logic [ADR_WIDTH-1:0] insn_pc_o,
  output logic                 insn_valid_o,
  input  logic                 insn_ready_i,
  input  logic                 redirect_i,
  input  logic [ADR_WIDTH-1:0] redirect_pc_i,
  output logic                 fault_o,
  output logic [ADR_WIDTH-1:0] fault_pc_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADR_WIDTH-1:0] STEP =
    ADR_WIDTH'(DAT_WIDTH / 8);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    FAULT
  } state_t;

  state_t                 state_q, state_d;
  logic [ADR_WIDTH-1:0]   pc_q, pc_d;
  logic                   stb_q, stb_d;
  logic [DAT_WIDTH-1:0]   insn_q, insn_d;
  logic [ADR_WIDTH-1:0]   ipc_q, ipc_d;
  logic                   valid_q, valid_d;
  logic                   fault_q, fault_d;
  logic [ADR_WIDTH-1:0]   fpc_q, fpc_d;
  logic                   discard_q, discard_d;
  logic                   mis_q, mis_d;
  logic [TW-1:0]          timer_q, timer_d;

  logic          misaligned;
  logic          timed_out;
  logic [TW-1:0] timer_inc;

  assign misaligned = |redirect_pc_i[2:0];
  assign timed_out  = timer_q >= T_LAST;
  assign timer_inc  = (timer_q == T_MAX) ? timer_q
                                         : timer_q + 1'b1;

  assign fetch_adr_o  = pc_q;
  assign fetch_dat_o  = '0;
  assign fetch_we_o   = 1'b0;
  assign fetch_cyc_o  = stb_q;
  assign fetch_stb_o  = stb_q;
  assign insn_o       = insn_q;
  assign insn_pc_o    = ipc_q;
  assign insn_valid_o = valid_q;
  assign fault_o      = fault_q;
  assign fault_pc_o   = fpc_q;

  // Next-state and registered-output decode; redirect overrides all.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stb_d     = stb_q;
    insn_d    = insn_q;
    ipc_d     = ipc_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    fpc_d     = fpc_q;
    discard_d = discard_q;
    mis_d     = mis_q;
    timer_d   = timer_q;
    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      valid_d = 1'b0;
      fault_d = 1'b0;
      if (state_q == REQ) begin
        discard_d = 1'b1;
        mis_d     = misaligned;
        timer_d   = timer_inc;
      end else if (misaligned) begin
        stb_d   = 1'b0;
        fault_d = 1'b1;
        fpc_d   = redirect_pc_i;
        state_d = FAULT;
      end else begin
        stb_d   = 1'b0;
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable_i) begin
            stb_d   = 1'b1;
            timer_d = '0;
            state_d = REQ;
          end
        end
        REQ: begin
          timer_d = timer_inc;
          if (fetch_err_i || fetch_ack_i || timed_out) begin
            stb_d = 1'b0;
            if (discard_q) begin
              discard_d = 1'b0;
              mis_d     = 1'b0;
              if (mis_q) begin
                fault_d = 1'b1;
                fpc_d   = pc_q;
                state_d = FAULT;
              end else begin
                state_d = IDLE;
              end
            end else if (fetch_err_i || timed_out) begin
              fault_d = 1'b1;
              fpc_d   = pc_q;
              state_d = FAULT;
            end else begin
              insn_d  = fetch_dat_i;
              ipc_d   = pc_q;
              valid_d = 1'b1;
              pc_d    = pc_q + STEP;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (valid_q && insn_ready_i) begin
            valid_d = 1'b0;
            if (enable_i) begin
              stb_d   = 1'b1;
              timer_d = '0;
              state_d = REQ;
            end else begin
              state_d = IDLE;
            end
          end
        end
        FAULT: begin
          stb_d = 1'b0;
        end
        default: begin
          stb_d   = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      stb_q     <= 1'b0;
      insn_q    <= '0;
      ipc_q     <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      fpc_q     <= '0;
      discard_q <= 1'b0;
      mis_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      stb_q     <= stb_d;
      insn_q    <= insn_d;
      ipc_q     <= ipc_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      fpc_q     <= fpc_d;
      discard_q <= discard_d;
      mis_q     <= mis_d;
      timer_q   <= timer_d;
    end
  end

endmodule

// File: tb/tb_insn_fetch.sv
// tb_insn_fetch: directed and randomized bench for insn_fetch.
// Registered-ack Wishbone slave backed by a synthetic memory.
module tb_insn_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] adr;
  logic [63:0] rdat;
  logic [63:0] wdat;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  logic [63:0] insn;
  logic [31:0] insn_pc;
  logic        valid;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [31:0] err_adr = 32'hFFFF_FFFF;
  logic        mute    = 1'b0;
  logic [3:0]  lat_tgt = 4'd0;
  logic [3:0]  lat_cnt;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  insn_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .fetch_adr_o   (adr),
    .fetch_dat_i   (rdat),
    .fetch_dat_o   (wdat),
    .fetch_we_o    (we),
    .fetch_cyc_o   (cyc),
    .fetch_stb_o   (stb),
    .fetch_ack_i   (ack),
    .fetch_err_i   (err),
    .insn_o        (insn),
    .insn_pc_o     (insn_pc),
    .insn_valid_o  (valid),
    .insn_ready_i  (ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .fault_o       (fault),
    .fault_pc_o    (fault_pc)
  );

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 64'h0287800010001018;
    if (a == 32'h8) return 64'h1687800000008000;
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  // Registered-ack slave: responds after lat_tgt waits, holds
  // ack/err until it sees the strobe fall.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack     <= 1'b0;
      err     <= 1'b0;
      lat_cnt <= 4'd0;
      rdat    <= 64'd0;
    end else if (!(cyc && stb)) begin
      ack     <= 1'b0;
      err     <= 1'b0;
      lat_cnt <= 4'd0;
    end else if (!ack && !err && !mute) begin
      if (lat_cnt >= lat_tgt) begin
        if (adr == err_adr) err <= 1'b1;
        else begin
          ack  <= 1'b1;
          rdat <= mem_word(adr);
        end
      end else begin
        lat_cnt <= lat_cnt + 4'd1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid_bound", 64'(valid), 64'd1);
  endtask

  task automatic wait_fault(input int limit);
    int n;
    n = 0;
    while (!fault && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_fault_bound", 64'(fault), 64'd1);
  endtask

  task automatic redir(input logic [31:0] a);
    redirect    = 1'b1;
    redirect_pc = a;
    @(negedge clk);
    redirect    = 1'b0;
  endtask

  initial begin
    int t0;
    int hi;
    int accepted;
    logic [63:0] held;
    logic [31:0] exp_pc;

    rst         = 1'b1;
    enable      = 1'b0;
    ready       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_stb", 64'(stb), 64'd0);
    chk("rst_cyc", 64'(cyc), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_insn", insn, 64'd0);
    chk("rst_insn_pc", 64'(insn_pc), 64'd0);
    chk("rst_fault_pc", 64'(fault_pc), 64'd0);
    chk("rst_adr", 64'(adr), 64'd0);
    chk("we_zero", 64'(we), 64'd0);
    chk("wdat_zero", wdat, 64'd0);

    // 1: two sequential fetches, three-cycle spacing
    rst    = 1'b0;
    enable = 1'b1;
    ready  = 1'b1;
    wait_valid(20);
    chk("t1_insn0", insn, 64'h0287800010001018);
    chk("t1_pc0", 64'(insn_pc), 64'd0);
    chk("t1_stb_gap", 64'(stb), 64'd0);
    t0 = cycle;
    @(negedge clk);
    chk("t1_valid_1cyc", 64'(valid), 64'd0);
    chk("t1_adr8", 64'(adr), 64'd8);
    wait_valid(20);
    chk("t1_spacing", 64'(cycle - t0), 64'd3);
    chk("t1_insn1", insn, 64'h1687800000008000);
    chk("t1_pc1", 64'(insn_pc), 64'd8);
    chk("t1_stb_gap2", 64'(stb), 64'd0);

    // 2: decoder stalls for 10 cycles
    @(negedge clk);
    ready = 1'b0;
    wait_valid(20);
    chk("t2_pc", 64'(insn_pc), 64'h10);
    held = insn;
    chk("t2_insn", held, mem_word(32'h10));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", 64'(valid), 64'd1);
      chk("t2_hold_insn", insn, held);
      chk("t2_hold_stb", 64'(stb), 64'd0);
    end

    // 3: redirect while a slow request is outstanding
    lat_tgt = 4'd5;
    ready   = 1'b1;
    @(negedge clk);
    chk("t3_req_stb", 64'(stb), 64'd1);
    chk("t3_req_adr", 64'(adr), 64'h18);
    @(negedge clk);
    @(negedge clk);
    chk("t3_still_req", 64'(stb), 64'd1);
    redir(32'h48);
    chk("t3_discard_busy", 64'(stb), 64'd1);
    wait_valid(40);
    chk("t3_pc", 64'(insn_pc), 64'h48);
    chk("t3_insn", insn, mem_word(32'h48));
    lat_tgt = 4'd0;

    // 4: bus error at 0x20, then recovery by redirect
    err_adr = 32'h20;
    redir(32'h10);
    wait_fault(60);
    chk("t4_fault_pc", 64'(fault_pc), 64'h20);
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (stb) hi++;
    end
    chk("t4_no_stb", 64'(hi), 64'd0);
    redir(32'h0);
    chk("t4_fault_clr", 64'(fault), 64'd0);
    err_adr = 32'hFFFF_FFFF;
    wait_valid(20);
    chk("t4_resume_pc", 64'(insn_pc), 64'd0);
    chk("t4_resume_insn", insn, mem_word(32'h0));

    // 5: silent slave, fetch at 0x8 times out
    mute = 1'b1;
    hi   = 0;
    for (int i = 0; i < 400 && !fault; i++) begin
      @(negedge clk);
      if (stb) hi++;
    end
    chk("t5_fault", 64'(fault), 64'd1);
    chk("t5_stb_cycles", 64'(hi), 64'd255);
    chk("t5_fault_pc", 64'(fault_pc), 64'd8);
    chk("t5_stb_low", 64'(stb), 64'd0);
    mute = 1'b0;

    // 6: misaligned redirect, in FAULT and in REQ
    redir(32'h4);
    chk("t6_fault", 64'(fault), 64'd1);
    chk("t6_fault_pc", 64'(fault_pc), 64'h4);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (stb) hi++;
    end
    chk("t6_no_bus", 64'(hi), 64'd0);
    lat_tgt = 4'd5;
    redir(32'h40);
    chk("t6_fault_clr", 64'(fault), 64'd0);
    @(negedge clk);
    chk("t6_req_stb", 64'(stb), 64'd1);
    chk("t6_req_adr", 64'(adr), 64'h40);
    redir(32'hC);
    chk("t6_mis_pending", 64'(fault), 64'd0);
    wait_fault(30);
    chk("t6_mis_fault_pc", 64'(fault_pc), 64'hC);
    chk("t6_mis_no_valid", 64'(valid), 64'd0);
    redir(32'h40);
    @(negedge clk);
    chk("t6_req2_stb", 64'(stb), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_stb", 64'(stb), 64'd0);
    chk("t6_async_cyc", 64'(cyc), 64'd0);
    chk("t6_async_pc", 64'(adr), 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    lat_tgt = 4'd0;

    // Randomized traffic against the instruction-stream model
    exp_pc   = 32'd0;
    accepted = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      chk("r_cyc_eq_stb", 64'(cyc), 64'(stb));
      chk("r_stb_valid_excl", 64'(stb & valid), 64'd0);
      if (stb) chk("r_adr", 64'(adr), 64'(exp_pc));
      if (valid) begin
        chk("r_insn_pc", 64'(insn_pc), 64'(exp_pc));
        chk("r_insn", insn, mem_word(exp_pc));
      end
      lat_tgt  = 4'($urandom_range(0, 3));
      enable   = ($urandom_range(0, 3) != 0);
      ready    = ($urandom_range(0, 2) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      if (redirect) begin
        redirect_pc = 32'($urandom_range(0, 63)) << 3;
        exp_pc      = redirect_pc;
      end else if (valid && ready) begin
        exp_pc = exp_pc + 32'd8;
        accepted++;
      end
    end
    redirect = 1'b0;
    chk("r_progress", 64'(accepted > 40), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
